// File: rtl/aes_pkg.sv
// Shared constants and state type for the AES-256 round key store.
package aes_pkg;

    localparam int NUM_RK_256 = 15;
    localparam int AES_KEY_W  = 128;
    localparam int RK_IDX_W   = 4;

    typedef enum logic [1:0] {
        RKS_EMPTY     = 2'd0,
        RKS_LOADING   = 2'd1,
        RKS_LOADED    = 2'd2,
        RKS_STREAMING = 2'd3
    } rks_state_t;

endpackage

// File: rtl/aes256_round_key_store_regfile.sv
// Round key storage: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module rk_regfile
    import aes_pkg::*;
#(
    parameter int NUM_RK = NUM_RK_256,
    parameter int KEY_W  = AES_KEY_W,
    parameter int IDX_W  = RK_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [KEY_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [KEY_W-1:0] rd_data
);

    logic [KEY_W-1:0] mem_q [NUM_RK];
    logic [KEY_W-1:0] rd_data_d;
    logic [KEY_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < NUM_RK)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data holds when rd_en is low so a stalled consumer sees a stable key.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en && (int'(rd_addr) < NUM_RK)) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/aes256_round_key_store.sv
// Captures the AES-256 key schedule once and replays it forward (encrypt)
// or backward (decrypt) to the cipher datapath as often as needed.
module aes256_round_key_store
    import aes_pkg::*;
#(
    parameter int NUM_RK = NUM_RK_256,
    parameter int KEY_W  = AES_KEY_W,
    parameter int IDX_W  = RK_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ke_rdy,
    input  logic [KEY_W-1:0] ke_subkey,
    input  logic             rk_start,
    input  logic             rk_decrypt,
    input  logic             rk_stall,
    output logic [KEY_W-1:0] rk_out,
    output logic             rk_valid,
    output logic [IDX_W-1:0] rk_index,
    output logic             rk_last,
    output logic             keys_loaded,
    output logic             busy,
    output logic             load_err,
    output rks_state_t       dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RK - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    rks_state_t       state_q, state_d;
    logic [IDX_W-1:0] wptr_q, wptr_d;
    logic [IDX_W-1:0] rptr_q, rptr_d;
    logic             dec_q, dec_d;
    logic             rk_valid_q, rk_valid_d;
    logic             rk_last_q, rk_last_d;
    logic             keys_loaded_q, keys_loaded_d;
    logic             load_err_q, load_err_d;
    logic             busy_q, busy_d;
    logic             ke_rdy_prev_q;

    logic             ke_rise;
    logic             start_load;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic             rd_en;

    assign ke_rise = ke_rdy && !ke_rdy_prev_q;

    // Replay handshake: a key is taken on a rising edge where rk_valid=1 and
    // rk_stall=0; while rk_stall=1 rk_out/rk_index/rk_valid/rk_last all hold.
    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        dec_d         = dec_q;
        rk_valid_d    = rk_valid_q;
        rk_last_d     = rk_last_q;
        keys_loaded_d = keys_loaded_q;
        load_err_d    = load_err_q;
        start_load    = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = wptr_q;
        rd_en         = 1'b0;

        case (state_q)
            RKS_EMPTY: begin
                start_load = ke_rdy;
            end
            RKS_LOADING: begin
                if (ke_rdy) begin
                    wr_en = 1'b1;
                    if (wptr_q == LAST_IDX) begin
                        state_d       = RKS_LOADED;
                        keys_loaded_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + IDX_ONE;
                    end
                end else begin
                    state_d    = RKS_EMPTY;
                    load_err_d = 1'b1;
                    wptr_d     = '0;
                end
            end
            RKS_LOADED: begin
                if (ke_rise) begin
                    start_load = 1'b1;
                end else if (rk_start) begin
                    dec_d      = rk_decrypt;
                    rptr_d     = rk_decrypt ? LAST_IDX : '0;
                    rk_valid_d = 1'b1;
                    rk_last_d  = (NUM_RK == 1);
                    rd_en      = 1'b1;
                    state_d    = RKS_STREAMING;
                end
            end
            RKS_STREAMING: begin
                if (ke_rise) begin
                    start_load = 1'b1;
                end else if (!rk_stall) begin
                    if (rk_last_q) begin
                        rk_valid_d = 1'b0;
                        rk_last_d  = 1'b0;
                        state_d    = RKS_LOADED;
                    end else begin
                        // The end-of-replay check stops the pointer before it can wrap.
                        rptr_d    = dec_q ? (rptr_q - IDX_ONE) : (rptr_q + IDX_ONE);
                        rk_last_d = dec_q ? (rptr_d == '0) : (rptr_d == LAST_IDX);
                        rd_en     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RKS_EMPTY;
            end
        endcase

        // A new load always overrides any replay in progress.
        if (start_load) begin
            wr_en         = 1'b1;
            wr_addr       = '0;
            wptr_d        = IDX_ONE;
            state_d       = RKS_LOADING;
            load_err_d    = 1'b0;
            keys_loaded_d = 1'b0;
            rk_valid_d    = 1'b0;
            rk_last_d     = 1'b0;
        end

        busy_d = (state_d == RKS_LOADING) || (state_d == RKS_STREAMING);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RKS_EMPTY;
            wptr_q        <= '0;
            rptr_q        <= '0;
            dec_q         <= 1'b0;
            rk_valid_q    <= 1'b0;
            rk_last_q     <= 1'b0;
            keys_loaded_q <= 1'b0;
            load_err_q    <= 1'b0;
            busy_q        <= 1'b0;
            ke_rdy_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            dec_q         <= dec_d;
            rk_valid_q    <= rk_valid_d;
            rk_last_q     <= rk_last_d;
            keys_loaded_q <= keys_loaded_d;
            load_err_q    <= load_err_d;
            busy_q        <= busy_d;
            ke_rdy_prev_q <= ke_rdy;
        end
    end

    rk_regfile #(
        .NUM_RK (NUM_RK),
        .KEY_W  (KEY_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (ke_subkey),
        .rd_en   (rd_en),
        .rd_addr (rptr_d),
        .rd_data (rk_out)
    );

    assign rk_valid    = rk_valid_q;
    assign rk_index    = rptr_q;
    assign rk_last     = rk_last_q;
    assign keys_loaded = keys_loaded_q;
    assign busy        = busy_q;
    assign load_err    = load_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_aes256_round_key_store.sv
// Directed bench for aes256_round_key_store with an expected-key queue.
module tb_aes256_round_key_store;
    import aes_pkg::*;

    localparam int KW = 128;
    localparam int IW = 4;
    localparam int EW = 1 + IW + KW;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           ke_rdy = 1'b0;
    logic [KW-1:0]  ke_subkey = '0;
    logic           rk_start = 1'b0;
    logic           rk_decrypt = 1'b0;
    logic           rk_stall = 1'b0;
    logic [KW-1:0]  rk_out;
    logic           rk_valid;
    logic [IW-1:0]  rk_index;
    logic           rk_last;
    logic           keys_loaded;
    logic           busy;
    logic           load_err;
    rks_state_t     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [KW-1:0] model_keys [15];
    logic [EW-1:0] exp_q [$];

    aes256_round_key_store dut (
        .clk         (clk),
        .reset       (reset),
        .ke_rdy      (ke_rdy),
        .ke_subkey   (ke_subkey),
        .rk_start    (rk_start),
        .rk_decrypt  (rk_decrypt),
        .rk_stall    (rk_stall),
        .rk_out      (rk_out),
        .rk_valid    (rk_valid),
        .rk_index    (rk_index),
        .rk_last     (rk_last),
        .keys_loaded (keys_loaded),
        .busy        (busy),
        .load_err    (load_err),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KW-1:0] mk(input logic [7:0] b);
        return {4{24'h0, b}};
    endfunction

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] base, input int first, input int last_i);
        for (int i = first; i <= last_i; i++) begin
            ke_rdy        = 1'b1;
            ke_subkey     = mk(base + 8'(i));
            model_keys[i] = ke_subkey;
            step();
            if (i < 14) begin
                chk($sformatf("busy_load_%0d", i), busy, 1);
                chk($sformatf("kl_low_load_%0d", i), keys_loaded, 0);
            end
        end
    endtask

    task automatic replay(input bit dec, input int stall_at, input int stall_n,
                          input int abort_at, input logic [7:0] new_base);
        logic [IW-1:0] idx;
        int n_push, left, held, pops;
        for (int i = 0; i < 15; i++) begin
            idx = dec ? IW'(14 - i) : IW'(i);
            exp_q.push_back({(i == 14), idx, model_keys[idx]});
            if (abort_at >= 0 && int'(idx) == abort_at) break;
        end
        n_push = exp_q.size();
        rk_decrypt = dec;
        rk_start   = 1'b1;
        step();
        rk_start   = 1'b0;
        rk_decrypt = 1'b0;
        left = stall_n;
        held = 0;
        pops = 0;
        while (exp_q.size() > 0) begin
            if (rk_valid !== 1'b1) begin
                chk($sformatf("replay_valid_%0d", pops), rk_valid, 1);
                exp_q.delete();
                break;
            end
            rk_stall = 1'b0;
            if (int'(rk_index) == stall_at) begin
                held++;
                if (left > 0) begin
                    rk_stall = 1'b1;
                    left--;
                end
            end
            if (abort_at >= 0 && int'(rk_index) == abort_at) begin
                ke_rdy        = 1'b1;
                ke_subkey     = mk(new_base);
                model_keys[0] = ke_subkey;
            end
            chk($sformatf("key_%s_%0d", dec ? "dec" : "enc", pops), {rk_last, rk_index, rk_out}, exp_q[0]);
            if (!rk_stall) begin
                void'(exp_q.pop_front());
                pops++;
            end
            step();
        end
        rk_stall = 1'b0;
        if (stall_n > 0) chk("stall_hold_cycles", held, stall_n + 1);
        chk("keys_consumed", pops, n_push);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("reset_outputs", {rk_out, rk_valid, rk_index, rk_last, keys_loaded, busy, load_err}, '0);
        chk("reset_state", dbg_state, RKS_EMPTY);
        reset = 1'b1;
        step();

        // Normal load of {4{24'h0, i}}
        load(8'h00, 0, 14);
        chk("full_keys_loaded", keys_loaded, 1);
        chk("full_load_err", load_err, 0);
        chk("full_busy", busy, 0);
        chk("full_state", dbg_state, RKS_LOADED);
        ke_rdy = 1'b0;
        step();

        // Encrypt replay
        replay(1'b0, -1, 0, -1, 8'h00);
        chk("enc_end_valid", rk_valid, 0);
        chk("enc_end_state", dbg_state, RKS_LOADED);

        // Decrypt replay with a 3-cycle stall at index 10
        replay(1'b1, 10, 3, -1, 8'h00);
        chk("dec_end_valid", rk_valid, 0);
        chk("dec_end_state", dbg_state, RKS_LOADED);

        // Short load: 7 words then ke_rdy drops
        load(8'h50, 0, 6);
        ke_rdy = 1'b0;
        step();
        chk("short_load_err", load_err, 1);
        chk("short_keys_loaded", keys_loaded, 0);
        chk("short_state", dbg_state, RKS_EMPTY);
        rk_start = 1'b1;
        step();
        rk_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("short_no_valid_%0d", i), rk_valid, 0);
            step();
        end

        // Reload mid-stream at rk_index 5 with A0.. words
        load(8'h00, 0, 14);
        ke_rdy = 1'b0;
        step();
        chk("reload_prep_loaded", keys_loaded, 1);
        replay(1'b0, -1, 0, 5, 8'hA0);
        chk("abort_valid", rk_valid, 0);
        chk("abort_state", dbg_state, RKS_LOADING);
        load(8'hA0, 1, 14);
        chk("reload_keys_loaded", keys_loaded, 1);
        ke_rdy = 1'b0;
        step();
        replay(1'b0, -1, 0, -1, 8'h00);
        chk("reload_end_state", dbg_state, RKS_LOADED);

        // ke_rdy rising edge together with rk_start: the load wins
        ke_rdy        = 1'b1;
        ke_subkey     = mk(8'hC0);
        model_keys[0] = ke_subkey;
        rk_start      = 1'b1;
        step();
        rk_start = 1'b0;
        chk("race_valid", rk_valid, 0);
        chk("race_state", dbg_state, RKS_LOADING);
        load(8'hC0, 1, 14);
        ke_rdy = 1'b0;
        step();
        chk("race_keys_loaded", keys_loaded, 1);
        replay(1'b1, -1, 0, -1, 8'h00);

        // Async reset mid-stream
        rk_start = 1'b1;
        step();
        rk_start = 1'b0;
        step();
        step();
        chk("pre_reset_valid", rk_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_flags", {rk_valid, keys_loaded, busy, load_err}, '0);
        chk("async_reset_state", dbg_state, RKS_EMPTY);
        step();
        reset = 1'b1;
        rk_start = 1'b1;
        step();
        rk_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("post_reset_no_valid_%0d", i), rk_valid, 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
